adder_pipe: RTL



---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_pipe_stage.sv | 52 +++++
 rtl/adder_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types, defaults and operand-extension helper for adder_pipe.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEFAULT_WIDTH = 8;

    // Widest operand the helper handles; adder_pipe WIDTH must not exceed it.
    localparam int MAX_WIDTH = 64;

    // Extends a left-justified operand by one bit. Callers place the operand
    // MSB at bit MAX_WIDTH-1 so the sign bit sits at a fixed position for any
    // WIDTH. The WIDTH+1-bit extension is then the top WIDTH+1 bits of the result.
    function automatic logic [MAX_WIDTH:0] ext_operand(
        input logic [MAX_WIDTH-1:0] value,
        input logic                 is_signed
    );
        return {is_signed & value[MAX_WIDTH-1], value};
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: one delay slice carrying {valid, result, sat_ovf}.
// Data loads only when a valid beat enters, so the result holds across bubbles.
module adder_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           in_valid,
    input  logic [WIDTH:0] in_result,
    input  logic           in_sat,
    output logic           out_valid,
    output logic [WIDTH:0] out_result,
    output logic           out_sat
);

    logic           valid_q,  valid_d;
    logic [WIDTH:0] result_q, result_d;
    logic           sat_q,    sat_d;

    // Next state: advance on enable, capture data only for valid beats.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        sat_d    = sat_q;
        if (en) begin
            valid_d = in_valid;
            if (in_valid) begin
                result_d = in_result;
                sat_d    = in_sat;
            end
        end
    end

    // Slice registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_sat    = sat_q;

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit add/sub with valid/ready backpressure.
// The first stage computes the exact WIDTH+1-bit result; STAGES-1 slices delay it.
// Define ADDER_PIPE_SAT_EN to clamp results to the WIDTH-bit range and add sat_ovf.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  op_e            op,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] out
`ifdef ADDER_PIPE_SAT_EN
    ,
    output logic           sat_ovf
`endif
);

    // One global enable: a stalled output freezes every stage.
    logic en;
    assign in_ready = !(out_valid && !out_ready);
    assign en       = in_ready;

    logic [MAX_WIDTH-1:0] a_w, b_w;
    logic [WIDTH:0]       a_x, b_x, exact, res_c;
    logic                 sat_c;

    // Operand extension, exact arithmetic and optional clamping.
    always_comb begin
        a_w = '0;
        b_w = '0;
        a_w[MAX_WIDTH-1 -: WIDTH] = in1;
        b_w[MAX_WIDTH-1 -: WIDTH] = in2;
        a_x   = (WIDTH+1)'(ext_operand(a_w, is_signed) >> (MAX_WIDTH - WIDTH));
        b_x   = (WIDTH+1)'(ext_operand(b_w, is_signed) >> (MAX_WIDTH - WIDTH));
        exact = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
        res_c = exact;
        sat_c = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
        if (is_signed) begin
            // Out of signed range when the top two bits disagree.
            if (exact[WIDTH] != exact[WIDTH-1]) begin
                sat_c = 1'b1;
                res_c = exact[WIDTH] ? {2'b11, {(WIDTH-1){1'b0}}}
                                     : {2'b00, {(WIDTH-1){1'b1}}};
            end
        end else if (exact[WIDTH]) begin
            // Carry clamps to max; borrow clamps to zero.
            sat_c = 1'b1;
            res_c = (op == OP_SUB) ? '0 : {1'b0, {WIDTH{1'b1}}};
        end
`endif
    end

    logic           valid0_q,  valid0_d;
    logic [WIDTH:0] result0_q, result0_d;
    logic           sat0_q,    sat0_d;

    // Compute-stage next state: accept a beat when enabled.
    always_comb begin
        valid0_d  = valid0_q;
        result0_d = result0_q;
        sat0_d    = sat0_q;
        if (en) begin
            valid0_d = in_valid;
            if (in_valid) begin
                result0_d = res_c;
                sat0_d    = sat_c;
            end
        end
    end

    // Compute-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid0_q  <= 1'b0;
            result0_q <= '0;
            sat0_q    <= 1'b0;
        end else begin
            valid0_q  <= valid0_d;
            result0_q <= result0_d;
            sat0_q    <= sat0_d;
        end
    end

    logic           stg_valid  [STAGES];
    logic [WIDTH:0] stg_result [STAGES];
    logic           stg_sat    [STAGES];

    assign stg_valid[0]  = valid0_q;
    assign stg_result[0] = result0_q;
    assign stg_sat[0]    = sat0_q;

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        adder_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .in_valid   (stg_valid[g-1]),
            .in_result  (stg_result[g-1]),
            .in_sat     (stg_sat[g-1]),
            .out_valid  (stg_valid[g]),
            .out_result (stg_result[g]),
            .out_sat    (stg_sat[g])
        );
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out       = stg_result[STAGES-1];

`ifdef ADDER_PIPE_SAT_EN
    assign sat_ovf = stg_sat[STAGES-1];
`else
    logic sat_unused;
    assign sat_unused = stg_sat[STAGES-1];
`endif

endmodule
